// File: rtl/bram_mux_pkg.sv
// Shared constants, read-tag type and bank decode helper for the pipelined BRAM mux.
package bram_mux_pkg;

    localparam int BANK_SEL_INTERLEAVE = 0;
    localparam int BANK_SEL_BLOCK      = 1;
    localparam int TAG_BANK_W          = 8;

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [TAG_BANK_W-1:0] bank_id;
    } rd_tag_t;

    // Bank number before the range check; blocked mode may yield ids >= NB_BRAMS.
    function automatic logic [TAG_BANK_W-1:0] bank_decode(
        input logic [31:0] addr,
        input int          row_w,
        input int          id_w,
        input int          mode
    );
        logic [31:0] mask_s;
        logic [31:0] raw_s;
        mask_s = (32'd1 << id_w) - 32'd1;
        if (mode == BANK_SEL_BLOCK) begin
            raw_s = (addr >> row_w) & mask_s;
        end else begin
            raw_s = addr & mask_s;
        end
        return TAG_BANK_W'(raw_s);
    endfunction

endpackage

// File: rtl/bram_mux_pipelined_if.sv
// Flat-address request/response bus plus the per-bank BRAM side of the mux.
interface bram_mux_pipelined_if #(
    parameter int NB_BRAMS        = 4,
    parameter int BANK_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH      = 64
);
    localparam int ADDR_WIDTH = BANK_ADDR_WIDTH + $clog2(NB_BRAMS);

    logic [ADDR_WIDTH-1:0]                          in_addr;
    logic [DATA_WIDTH-1:0]                          in_wr_data;
    logic                                           in_wr_en;
    logic                                           in_rd_en;
    logic [DATA_WIDTH-1:0]                          in_rd_data;
    logic                                           in_rd_valid;
    logic                                           in_rd_err;
    logic [NB_BRAMS-1:0][BANK_ADDR_WIDTH-1:0]       out_addr;
    logic [NB_BRAMS-1:0][DATA_WIDTH-1:0]            out_wr_data;
    logic [NB_BRAMS-1:0]                            out_wr_en;
    logic [NB_BRAMS-1:0]                            out_rd_en;
    logic [NB_BRAMS-1:0][DATA_WIDTH-1:0]            out_rd_data;

    modport slave (
        input  in_addr, in_wr_data, in_wr_en, in_rd_en, out_rd_data,
        output in_rd_data, in_rd_valid, in_rd_err,
               out_addr, out_wr_data, out_wr_en, out_rd_en
    );

    modport master (
        output in_addr, in_wr_data, in_wr_en, in_rd_en, out_rd_data,
        input  in_rd_data, in_rd_valid, in_rd_err,
               out_addr, out_wr_data, out_wr_en, out_rd_en
    );

endinterface

// File: rtl/bram_rd_tag_pipe.sv
// Fixed-depth shift register carrying read tags alongside the bank read latency.
module bram_rd_tag_pipe
    import bram_mux_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t pipe_q [DEPTH];

    // Advance every cycle; reset drops all in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/bram_mux_pipelined.sv
// Joins NB_BRAMS banks into one flat address space with fully pipelined, in-order reads.
module bram_mux_pipelined
    import bram_mux_pkg::*;
#(
    parameter int NB_BRAMS        = 4,
    parameter int BANK_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH      = 64,
    parameter int BRAM_RD_LATENCY = 2,
    parameter int BANK_SEL_MODE   = BANK_SEL_INTERLEAVE,
    parameter int ERR_CNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bram_mux_pipelined_if.slave      bus,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    localparam int BANK_ID_WIDTH = $clog2(NB_BRAMS);
    localparam int ADDR_WIDTH    = BANK_ADDR_WIDTH + BANK_ID_WIDTH;

    if (NB_BRAMS < 32'sd2 || NB_BRAMS > (32'sd1 << TAG_BANK_W)) begin : g_chk_nb
        $error("bram_mux_pipelined: NB_BRAMS out of supported range");
    end
    if (BANK_SEL_MODE == BANK_SEL_INTERLEAVE && (NB_BRAMS & (NB_BRAMS - 32'sd1)) != 32'sd0) begin : g_chk_pow2
        $error("bram_mux_pipelined: interleaved mode needs NB_BRAMS to be a power of two");
    end
    if (BRAM_RD_LATENCY < 32'sd1 || BRAM_RD_LATENCY > 32'sd4) begin : g_chk_lat
        $error("bram_mux_pipelined: BRAM_RD_LATENCY must be 1..4");
    end
    if (ADDR_WIDTH > 32'sd32) begin : g_chk_aw
        $error("bram_mux_pipelined: flat address wider than 32 bits");
    end

    logic [TAG_BANK_W-1:0]                    bank_s;
    logic [BANK_ADDR_WIDTH-1:0]               row_s;
    logic                                     in_range_s;
    logic                                     req_s;

    logic [NB_BRAMS-1:0][BANK_ADDR_WIDTH-1:0] out_addr_q,    out_addr_d;
    logic [NB_BRAMS-1:0][DATA_WIDTH-1:0]      out_wr_data_q, out_wr_data_d;
    logic [NB_BRAMS-1:0]                      out_wr_en_q,   out_wr_en_d;
    logic [NB_BRAMS-1:0]                      out_rd_en_q,   out_rd_en_d;
    logic [ERR_CNT_WIDTH-1:0]                 err_cnt_q,     err_cnt_d;
    logic [DATA_WIDTH-1:0]                    rd_data_q,     rd_data_d;
    logic                                     rd_valid_q,    rd_valid_d;
    logic                                     rd_err_q,      rd_err_d;

    rd_tag_t                                  tag_in_s;
    rd_tag_t                                  tag_tail_s;
    logic [DATA_WIDTH-1:0]                    bank_rd_data_s;

    assign bank_s     = bank_decode(32'(bus.in_addr), BANK_ADDR_WIDTH, BANK_ID_WIDTH, BANK_SEL_MODE);
    assign in_range_s = (bank_s < TAG_BANK_W'(NB_BRAMS));
    assign req_s      = bus.in_rd_en | bus.in_wr_en;

    if (BANK_SEL_MODE == BANK_SEL_BLOCK) begin : g_row_block
        assign row_s = bus.in_addr[BANK_ADDR_WIDTH-1:0];
    end else begin : g_row_interleave
        assign row_s = bus.in_addr[ADDR_WIDTH-1:BANK_ID_WIDTH];
    end

    // Request steering: only the selected bank is loaded, the rest keep addr/data.
    always_comb begin
        out_addr_d    = out_addr_q;
        out_wr_data_d = out_wr_data_q;
        out_wr_en_d   = '0;
        out_rd_en_d   = '0;
        for (int b = 0; b < NB_BRAMS; b++) begin
            if (req_s && in_range_s && (bank_s == TAG_BANK_W'(b))) begin
                out_addr_d[b]    = row_s;
                out_wr_data_d[b] = bus.in_wr_data;
                out_wr_en_d[b]   = bus.in_wr_en;
                out_rd_en_d[b]   = bus.in_rd_en;
            end else begin
                out_wr_en_d[b]   = 1'b0;
                out_rd_en_d[b]   = 1'b0;
            end
        end
        // A combined rd+wr is a single access, so it counts once.
        if (req_s && !in_range_s && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1'b1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    always_comb begin
        tag_in_s         = '0;
        tag_in_s.valid   = bus.in_rd_en;
        tag_in_s.err     = ~in_range_s;
        tag_in_s.bank_id = bank_s;
    end

    bram_rd_tag_pipe #(
        .DEPTH (BRAM_RD_LATENCY + 1)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_i (tag_in_s),
        .tag_o (tag_tail_s)
    );

    // Response selection from the bank named by the tag leaving the pipe.
    always_comb begin
        bank_rd_data_s = '0;
        for (int b = 0; b < NB_BRAMS; b++) begin
            if (tag_tail_s.bank_id == TAG_BANK_W'(b)) begin
                bank_rd_data_s = bus.out_rd_data[b];
            end else begin
                bank_rd_data_s = bank_rd_data_s;
            end
        end
        if (tag_tail_s.valid) begin
            rd_valid_d = 1'b1;
            rd_err_d   = tag_tail_s.err;
            rd_data_d  = tag_tail_s.err ? '0 : bank_rd_data_s;
        end else begin
            rd_valid_d = 1'b0;
            rd_err_d   = 1'b0;
            rd_data_d  = rd_data_q;
        end
    end

    // State registers for the request stage, error counter and response stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr_q    <= '0;
            out_wr_data_q <= '0;
            out_wr_en_q   <= '0;
            out_rd_en_q   <= '0;
            err_cnt_q     <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            rd_err_q      <= 1'b0;
        end else begin
            out_addr_q    <= out_addr_d;
            out_wr_data_q <= out_wr_data_d;
            out_wr_en_q   <= out_wr_en_d;
            out_rd_en_q   <= out_rd_en_d;
            err_cnt_q     <= err_cnt_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            rd_err_q      <= rd_err_d;
        end
    end

    assign bus.out_addr    = out_addr_q;
    assign bus.out_wr_data = out_wr_data_q;
    assign bus.out_wr_en   = out_wr_en_q;
    assign bus.out_rd_en   = out_rd_en_q;
    assign bus.in_rd_data  = rd_data_q;
    assign bus.in_rd_valid = rd_valid_q;
    assign bus.in_rd_err   = rd_err_q;
    assign err_cnt         = err_cnt_q;

endmodule

// File: doc/bram_mux_pipelined.md
Name: bram_mux_pipelined

Overview:
Parametrised successor to the PCIe-side BRAM joiner. It presents NB_BRAMS independent BRAM banks as one flat address space. Bank selection is either interleaved (low address bits) or blocked (high address bits). Reads are fully pipelined with a tag shift register, so any number of back-to-back reads to mixed banks return in order with an explicit valid. The block sits between PCIe register/queue logic and the per-queue BRAM banks.

Parameters:
NB_BRAMS, 4, number of banks (>=2)
BANK_ADDR_WIDTH, 10, address width of each bank
DATA_WIDTH, 64, data width of every bank
BRAM_RD_LATENCY, 2, cycles from bank rd_en to valid bank rd_data (1..4)
BANK_SEL_MODE, 0, 0 = interleaved (bank = low bits), 1 = blocked (bank = high bits)
ERR_CNT_WIDTH, 16, width of the out-of-range error counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_addr  in  BANK_ADDR_WIDTH+BANK_ID_WIDTH  flat address; BANK_ID_WIDTH = $clog2(NB_BRAMS)
in_wr_data  in  DATA_WIDTH  write data
in_wr_en  in  1  write strobe
in_rd_en  in  1  read strobe
in_rd_data  out  DATA_WIDTH  read data, valid with in_rd_valid
in_rd_valid  out  1  one-cycle pulse per accepted read
in_rd_err  out  1  qualifies in_rd_valid: the read targeted a nonexistent bank
out_addr  out  NB_BRAMS x BANK_ADDR_WIDTH  per-bank address
out_wr_data  out  NB_BRAMS x DATA_WIDTH  per-bank write data
out_wr_en  out  NB_BRAMS  per-bank write strobe
out_rd_en  out  NB_BRAMS  per-bank read strobe
out_rd_data  in  NB_BRAMS x DATA_WIDTH  per-bank read data
err_cnt  out  ERR_CNT_WIDTH  saturating count of out-of-range accesses

Behaviour:
- Reset (async assert, sync deassert handled upstream): all out_*_en=0, out_addr=0, out_wr_data=0, in_rd_data=0, in_rd_valid=0, in_rd_err=0, err_cnt=0, tag pipeline cleared.
- Decode, mode 0: bank = in_addr[BANK_ID_WIDTH-1:0], row = upper bits. NB_BRAMS must be a power of two; otherwise elaboration fails with $error.
- Decode, mode 1: bank = in_addr[top BANK_ID_WIDTH bits], row = low bits. A bank >= NB_BRAMS is out of range.
- Request stage (1 cycle): the selected bank gets addr, wr_data, wr_en and rd_en registered. All other banks get wr_en=rd_en=0 in that cycle; their addr/wr_data hold.
- Write latency: 1 cycle from in_wr_en to out_wr_en.
- Read latency: fixed L = BRAM_RD_LATENCY+2 cycles from in_rd_en to in_rd_valid (1 request stage + bank latency + 1 output register).
- Tag pipeline: depth BRAM_RD_LATENCY+1, entry = {valid, err, bank_id}, advances every cycle (no stall). At the tail, in_rd_data <= out_rd_data[bank_id]. in_rd_data holds its value when no read completes.
- Throughput: 1 request per cycle sustained. Responses are in request order.
- in_rd_en and in_wr_en in the same cycle: both go to the same bank. The mux does no forwarding; returned data is whatever the bank returns.
- Out-of-range request: no out_* strobe is asserted and err_cnt increments by 1, saturating at all-ones. A read still produces in_rd_valid at latency L, with in_rd_err=1 and in_rd_data=0. A simultaneous rd+wr to an out-of-range address counts once.
- Reset mid-operation: in-flight reads are dropped. No in_rd_valid appears after rst_n deasserts until a new read is issued.

Decomposition:
- Package bram_mux_pkg holds the BANK_SEL_INTERLEAVE/BANK_SEL_BLOCK constants, the rd_tag_t struct {valid, err, bank_id}, and a bank_decode function.
- One sub-module, bram_rd_tag_pipe: a parametrised depth shift register of rd_tag_t with async reset.

Test Plan:
- NB_BRAMS=4, mode 0: write addr 0x9 data 0xAB -> next cycle out_wr_en=4'b0010, out_addr[1]=0x2, out_wr_data[1]=0xAB; other enables 0.
- BRAM_RD_LATENCY=2, reads at cycles 0..3 to addrs 0,1,2,3 (bank models return bank*0x100+row) -> in_rd_valid cycles 4..7 with data 0x000,0x100,0x200,0x300.
- Mode 1, NB_BRAMS=3, BANK_ADDR_WIDTH=4: read addr 0x35 -> no out_rd_en; cycle 4 in_rd_valid=1, in_rd_err=1, data 0; err_cnt=1.
- ERR_CNT_WIDTH=2: five out-of-range writes -> err_cnt sequence 1,2,3,3,3.
- Read addr 0x4 at cycle 0, rst_n low at cycle 2 for 1 cycle -> all outputs 0 immediately; in_rd_valid never asserts for that read.
- Same-cycle rd+wr to addr 0x5 (mode 0) -> out_rd_en[1] and out_wr_en[1] both high one cycle later; one in_rd_valid at latency 4.
